// File: rtl/rgb_to_gray_axis.sv
// ============================================================================
// Module   : rgb_to_gray_axis
// Function : Pipelined AXI4-Stream RGB-to-luma converter, N pixels per beat.
//            Y = (77*R + 150*G + 29*B + 128) >> 8, three register stages,
//            tuser/tlast carried alongside each beat.
// Options  : RGB2GRAY_LINE_CHECK_EN - builds the line-length checker and its
//            three sticky error flags; when undefined the flags are tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rgb_to_gray_axis #(
  parameter int WIDTH                 = 3840,
  parameter int MAX_SAMPLES_PER_CLOCK = 4,
  parameter int DATA_WIDTH            = 8
) (
  input  logic                                            aclk,
  input  logic                                            aresetn,
  // RGB input stream
  input  logic [3*DATA_WIDTH*MAX_SAMPLES_PER_CLOCK-1:0]   s_axis_tdata,
  input  logic                                            s_axis_tvalid,
  input  logic                                            s_axis_tuser,
  input  logic                                            s_axis_tlast,
  output logic                                            s_axis_tready,
  // Gray output stream
  output logic [DATA_WIDTH*MAX_SAMPLES_PER_CLOCK-1:0]     m_axis_tdata,
  output logic                                            m_axis_tvalid,
  output logic                                            m_axis_tuser,
  output logic                                            m_axis_tlast,
  input  logic                                            m_axis_tready,
  // Sticky line-structure errors
  output logic                                            err_early_eol,
  output logic                                            err_late_eol,
  output logic                                            err_sof_midline
);

  localparam int N      = MAX_SAMPLES_PER_CLOCK;
  localparam int PIX_W  = 3 * DATA_WIDTH;
  localparam int IN_W   = PIX_W * N;
  localparam int OUT_W  = DATA_WIDTH * N;
  // Coefficients are 8-bit fractions of 256, so a product needs DATA_WIDTH+8
  // bits and so does the rounded sum (it never exceeds 256*max+128).
  localparam int PROD_W = DATA_WIDTH + 8;
  localparam int ACC_W  = DATA_WIDTH + 8;

  localparam logic [PROD_W-1:0] COEF_R = PROD_W'(77);
  localparam logic [PROD_W-1:0] COEF_G = PROD_W'(150);
  localparam logic [PROD_W-1:0] COEF_B = PROD_W'(29);
  localparam logic [ACC_W-1:0]  ROUND  = ACC_W'(128);

  // A line must hold a whole number of beats.
  if ((WIDTH % MAX_SAMPLES_PER_CLOCK) != 0) begin : g_bad_width
    $error("rgb_to_gray_axis: WIDTH must be a multiple of MAX_SAMPLES_PER_CLOCK");
  end

  // --------------------------------------------------------------------------
  // Stage state
  // --------------------------------------------------------------------------
  logic                          v1, v2, v3;
  logic                          en1, en2, en3;

  logic [IN_W-1:0]               s1_data;
  logic                          s1_user, s1_last;

  logic [N-1:0][PROD_W-1:0]      s2_prod_r, s2_prod_g, s2_prod_b;
  logic                          s2_user, s2_last;

  logic [OUT_W-1:0]              s3_data;
  logic                          s3_user, s3_last;

  // Per-lane combinational products (into S2) and packed gray (into S3)
  logic [N-1:0][PROD_W-1:0]      prod_r_c, prod_g_c, prod_b_c;
  logic [N-1:0][DATA_WIDTH-1:0]  gray_c;

  // A stage may load when it is empty or when the stage after it is moving,
  // which lets bubbles collapse without ever dropping a held beat.
  assign en3 = !v3 | m_axis_tready;
  assign en2 = !v2 | en3;
  assign en1 = !v1 | en2;
  assign s_axis_tready = en1;

  // --------------------------------------------------------------------------
  // Per-lane arithmetic
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [DATA_WIDTH-1:0] red, green, blue;
    logic [ACC_W-1:0]      acc;

    // Pixel layout within a 3*DATA_WIDTH slot: R high, then B, then G low.
    assign red   = s1_data[i*PIX_W + 2*DATA_WIDTH +: DATA_WIDTH];
    assign blue  = s1_data[i*PIX_W +   DATA_WIDTH +: DATA_WIDTH];
    assign green = s1_data[i*PIX_W                +: DATA_WIDTH];

    assign prod_r_c[i] = COEF_R * PROD_W'(red);
    assign prod_g_c[i] = COEF_G * PROD_W'(green);
    assign prod_b_c[i] = COEF_B * PROD_W'(blue);

    // Coefficients sum to 256, so the rounded sum cannot overflow ACC_W and
    // the shifted result always fits in DATA_WIDTH bits.
    assign acc       = s2_prod_r[i] + s2_prod_g[i] + s2_prod_b[i] + ROUND;
    assign gray_c[i] = DATA_WIDTH'(acc >> 8);
  end

  // --------------------------------------------------------------------------
  // Pipeline registers
  // --------------------------------------------------------------------------

  // Stage 1: capture the incoming beat whenever this stage can advance
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      v1      <= 1'b0;
      s1_data <= '0;
      s1_user <= 1'b0;
      s1_last <= 1'b0;
    end else if (en1) begin
      v1      <= s_axis_tvalid;
      s1_data <= s_axis_tdata;
      s1_user <= s_axis_tuser;
      s1_last <= s_axis_tlast;
    end
  end

  // Stage 2: register the three weighted products for every lane
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      v2        <= 1'b0;
      s2_prod_r <= '0;
      s2_prod_g <= '0;
      s2_prod_b <= '0;
      s2_user   <= 1'b0;
      s2_last   <= 1'b0;
    end else if (en2) begin
      v2        <= v1;
      s2_prod_r <= prod_r_c;
      s2_prod_g <= prod_g_c;
      s2_prod_b <= prod_b_c;
      s2_user   <= s1_user;
      s2_last   <= s1_last;
    end
  end

  // Stage 3: register the rounded, shifted and packed gray samples
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      v3      <= 1'b0;
      s3_data <= '0;
      s3_user <= 1'b0;
      s3_last <= 1'b0;
    end else if (en3) begin
      v3      <= v2;
      s3_data <= gray_c;
      s3_user <= s2_user;
      s3_last <= s2_last;
    end
  end

  assign m_axis_tdata  = s3_data;
  assign m_axis_tvalid = v3;
  assign m_axis_tuser  = s3_user;
  assign m_axis_tlast  = s3_last;

  // --------------------------------------------------------------------------
  // Line-length checker
  // --------------------------------------------------------------------------
`ifdef RGB2GRAY_LINE_CHECK_EN
  localparam int BEATS = WIDTH / MAX_SAMPLES_PER_CLOCK;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  logic [CNT_W-1:0] beat_cnt;
  logic             early_q, late_q, sof_q;
  logic             in_fire;

  assign in_fire = s_axis_tvalid & en1;

  // Track the beat position of accepted input beats and latch any
  // structural violation; the datapath is never affected.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      beat_cnt <= '0;
      early_q  <= 1'b0;
      late_q   <= 1'b0;
      sof_q    <= 1'b0;
    end else if (in_fire) begin
      if (s_axis_tuser && (beat_cnt != '0)) begin
        sof_q <= 1'b1;
      end
      if (!s_axis_tlast && (beat_cnt == LAST_BEAT)) begin
        late_q <= 1'b1;
      end
      // beat_cnt never exceeds LAST_BEAT, so "not last" means "too early".
      if (s_axis_tlast && (beat_cnt != LAST_BEAT)) begin
        early_q <= 1'b1;
      end

      // tlast closes the line no matter what; a mid-line tuser restarts the
      // count as if this beat were the first of a new line.
      if (s_axis_tlast) begin
        beat_cnt <= '0;
      end else if (s_axis_tuser && (beat_cnt != '0)) begin
        beat_cnt <= CNT_W'(1);
      end else if (beat_cnt == LAST_BEAT) begin
        beat_cnt <= '0;
      end else begin
        beat_cnt <= beat_cnt + CNT_W'(1);
      end
    end
  end

  assign err_early_eol   = early_q;
  assign err_late_eol    = late_q;
  assign err_sof_midline = sof_q;
`else
  assign err_early_eol   = 1'b0;
  assign err_late_eol    = 1'b0;
  assign err_sof_midline = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rgb_to_gray_axis.sv
// ============================================================================
// Module   : tb_rgb_to_gray_axis
// Function : Self-checking bench for rgb_to_gray_axis: directed luma vectors,
//            latency, burst sideband alignment, random backpressure against a
//            scoreboard, line-length checker flags and mid-flight reset.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_rgb_to_gray_axis;

  localparam int WIDTH      = 3840;
  localparam int N          = 4;
  localparam int DW         = 8;
  localparam int IN_W       = 3 * DW * N;
  localparam int OUT_W      = DW * N;
  localparam int LINE_BEATS = WIDTH / N;

`ifdef RGB2GRAY_LINE_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  typedef struct {
    logic [OUT_W-1:0] data;
    logic             user;
    logic             last;
  } beat_t;

  logic              clk = 1'b0;
  logic              aresetn;
  logic [IN_W-1:0]   s_axis_tdata;
  logic              s_axis_tvalid, s_axis_tuser, s_axis_tlast;
  logic              s_axis_tready;
  logic [OUT_W-1:0]  m_axis_tdata;
  logic              m_axis_tvalid, m_axis_tuser, m_axis_tlast;
  logic              m_axis_tready;
  logic              err_early_eol, err_late_eol, err_sof_midline;

  logic [1:0]        ready_mode;   // 0 = held low, 1 = held high, 2 = random
  logic              rnd_bit;
  logic              mon_en;
  beat_t             exp_q[$];
  int                n_checks;
  int                n_errors;

  rgb_to_gray_axis #(
    .WIDTH                 (WIDTH),
    .MAX_SAMPLES_PER_CLOCK (N),
    .DATA_WIDTH            (DW)
  ) dut (
    .aclk            (clk),
    .aresetn         (aresetn),
    .s_axis_tdata    (s_axis_tdata),
    .s_axis_tvalid   (s_axis_tvalid),
    .s_axis_tuser    (s_axis_tuser),
    .s_axis_tlast    (s_axis_tlast),
    .s_axis_tready   (s_axis_tready),
    .m_axis_tdata    (m_axis_tdata),
    .m_axis_tvalid   (m_axis_tvalid),
    .m_axis_tuser    (m_axis_tuser),
    .m_axis_tlast    (m_axis_tlast),
    .m_axis_tready   (m_axis_tready),
    .err_early_eol   (err_early_eol),
    .err_late_eol    (err_late_eol),
    .err_sof_midline (err_sof_midline)
  );

  always #5 clk = ~clk;

  assign m_axis_tready = (ready_mode == 2'd2) ? rnd_bit : ready_mode[0];

  // Fresh random downstream-ready bit each cycle, changed just after the edge
  always @(posedge clk) begin
    #1;
    rnd_bit = 1'($urandom_range(0, 1));
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference luma for every lane of a beat
  function automatic logic [OUT_W-1:0] model(input logic [IN_W-1:0] d);
    logic [OUT_W-1:0] res;
    int r, g, b, y;
    res = '0;
    for (int i = 0; i < N; i++) begin
      r = int'(d[24*i+16 +: 8]);
      b = int'(d[24*i+8  +: 8]);
      g = int'(d[24*i    +: 8]);
      y = (77*r + 150*g + 29*b + 128) >> 8;
      res[8*i +: 8] = y[7:0];
    end
    return res;
  endfunction

  // Output scoreboard: while valid, the head of the queue must be presented
  // (this also proves the beat is held during stalls); pop on handshake.
  always @(negedge clk) begin
    if (aresetn && mon_en && m_axis_tvalid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", 64'd1, 64'd0);
      end else begin
        check("out_data", 64'(m_axis_tdata), 64'(exp_q[0].data));
        check("out_user", 64'(m_axis_tuser), 64'(exp_q[0].user));
        check("out_last", 64'(m_axis_tlast), 64'(exp_q[0].last));
        if (m_axis_tready) void'(exp_q.pop_front());
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send_beat(input logic [IN_W-1:0] d, input logic u, input logic l);
    int t;
    t = 0;
    s_axis_tdata  = d;
    s_axis_tuser  = u;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    @(negedge clk);
    while (!s_axis_tready && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (!s_axis_tready) begin
      check("send_timeout", 64'd0, 64'd1);
    end else begin
      exp_q.push_back('{data: model(d), user: u, last: l});
    end
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
    s_axis_tuser  = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 5000) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("drain_left", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    ready_mode    = 2'd0;
    s_axis_tvalid = 1'b0;
    aresetn       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_valid", 64'(m_axis_tvalid), 64'd0);
    check("rst_m_user",  64'(m_axis_tuser),  64'd0);
    check("rst_m_last",  64'(m_axis_tlast),  64'd0);
    check("rst_m_data",  64'(m_axis_tdata),  64'd0);
    check("rst_flags",   64'({err_early_eol, err_late_eol, err_sof_midline}), 64'd0);
    aresetn = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    check("rst_s_ready", 64'(s_axis_tready), 64'd1);
  endtask

  logic [31:0] burst_gray [4];
  logic [IN_W-1:0] d;
  logic [7:0] v;

  initial begin
    n_checks = 0; n_errors = 0; mon_en = 1'b0; ready_mode = 2'd0; rnd_bit = 1'b0;
    aresetn = 1'b0; s_axis_tvalid = 1'b0; s_axis_tuser = 1'b0; s_axis_tlast = 1'b0;
    s_axis_tdata = '0;
    burst_gray[0] = 32'h13121110; burst_gray[1] = 32'h23222120;
    burst_gray[2] = 32'h33323130; burst_gray[3] = 32'h43424140;

    do_reset();

    // ---- Directed luma vectors and 3-stage latency ----
    ready_mode   = 2'd1;
    // lanes 0..3: white, red, green, blue  ->  255, 77, 149, 29
    s_axis_tdata  = {24'h00FF00, 24'h0000FF, 24'hFF0000, 24'hFFFFFF};
    s_axis_tvalid = 1'b1;
    @(posedge clk); #1;
    check("lat_p0_valid", 64'(m_axis_tvalid), 64'd0);
    s_axis_tdata  = {4{24'h646464}};            // (100,100,100) -> 100
    @(posedge clk); #1;
    s_axis_tvalid = 1'b0;
    check("lat_p1_valid", 64'(m_axis_tvalid), 64'd0);
    @(posedge clk); #1;
    check("lat_p2_valid", 64'(m_axis_tvalid), 64'd1);
    check("vec_primaries", 64'(m_axis_tdata), 64'h1D954DFF);
    @(posedge clk); #1;
    check("lat_p3_valid", 64'(m_axis_tvalid), 64'd1);
    check("vec_gray100", 64'(m_axis_tdata), 64'h64646464);
    @(posedge clk); #1;
    check("lat_p4_valid", 64'(m_axis_tvalid), 64'd0);

    // ---- 4-beat burst: gray pixels (v,v,v) map to v ----
    for (int k = 0; k < 7; k++) begin
      if (k < 4) begin
        for (int i = 0; i < N; i++) begin
          v = burst_gray[k][8*i +: 8];
          d[24*i +: 24] = {v, v, v};
        end
        s_axis_tdata  = d;
        s_axis_tuser  = (k == 0);
        s_axis_tlast  = (k == 3);
        s_axis_tvalid = 1'b1;
      end else begin
        s_axis_tvalid = 1'b0;
        s_axis_tuser  = 1'b0;
        s_axis_tlast  = 1'b0;
      end
      @(posedge clk); #1;
      if (k >= 2 && k <= 5) begin
        check("burst_valid", 64'(m_axis_tvalid), 64'd1);
        check("burst_data",  64'(m_axis_tdata),  64'(burst_gray[k-2]));
        check("burst_user",  64'(m_axis_tuser),  64'(k == 2));
        check("burst_last",  64'(m_axis_tlast),  64'(k == 5));
      end else if (k == 6) begin
        check("burst_end_valid", 64'(m_axis_tvalid), 64'd0);
      end
    end

    // ---- Full random line under 50% backpressure ----
    do_reset();
    mon_en     = 1'b1;
    ready_mode = 2'd2;
    for (int b = 0; b < LINE_BEATS; b++) begin
      send_beat({$urandom, $urandom, $urandom}, b == 0, b == LINE_BEATS - 1);
    end
    drain();
    ready_mode = 2'd1;
    check("good_line_flags", 64'({err_early_eol, err_late_eol, err_sof_midline}), 64'd0);

    // ---- Short line (959 beats) then long line (961 beats) ----
    for (int b = 1; b <= LINE_BEATS - 1; b++) begin
      send_beat({$urandom, $urandom, $urandom}, b == 1, b == LINE_BEATS - 1);
    end
    check("short_early", 64'(err_early_eol), 64'(CHK));
    check("short_late",  64'(err_late_eol),  64'd0);
    for (int b = 1; b <= LINE_BEATS + 1; b++) begin
      send_beat({$urandom, $urandom, $urandom}, b == 1, b == LINE_BEATS + 1);
      if (b == LINE_BEATS - 1) check("long_late_before", 64'(err_late_eol), 64'd0);
      if (b == LINE_BEATS)     check("long_late_at",     64'(err_late_eol), 64'(CHK));
    end
    drain();

    // ---- tuser on beat 5 of a line ----
    do_reset();
    ready_mode = 2'd1;
    for (int b = 1; b <= 6; b++) begin
      send_beat({$urandom, $urandom, $urandom}, (b == 1) || (b == 5), 1'b0);
      if (b == 4) check("sof_before", 64'(err_sof_midline), 64'd0);
      if (b == 5) check("sof_at",     64'(err_sof_midline), 64'(CHK));
    end
    drain();

    // ---- Reset with 3 beats stacked in the pipe ----
    ready_mode = 2'd0;
    for (int b = 0; b < 3; b++) send_beat({$urandom, $urandom, $urandom}, 1'b0, 1'b0);
    aresetn = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    aresetn = 1'b1;
    check("midrst_valid",   64'(m_axis_tvalid), 64'd0);
    check("midrst_flags",   64'({err_early_eol, err_late_eol, err_sof_midline}), 64'd0);
    check("midrst_s_ready", 64'(s_axis_tready), 64'd1);
    ready_mode = 2'd1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("midrst_no_stale", 64'(m_axis_tvalid), 64'd0);
    end
    send_beat({24'h000000, 24'hFFFFFF, 24'h646464, 24'hFF0000}, 1'b1, 1'b0);
    check("fresh_p0_valid", 64'(m_axis_tvalid), 64'd0);
    @(posedge clk); #1;
    check("fresh_p1_valid", 64'(m_axis_tvalid), 64'd0);
    @(posedge clk); #1;
    check("fresh_p2_valid", 64'(m_axis_tvalid), 64'd1);
    check("fresh_data",     64'(m_axis_tdata),  64'h00FF644D);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Hard stop if something hangs outside the bounded waits
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/rgb_to_gray_axis.md
# rgb_to_gray_axis

Pipelined AXI4-Stream colour-to-luma converter that sits directly upstream of the stereovision core. It accepts packed 24-bit RGB video at MAX_SAMPLES_PER_CLOCK pixels per beat and emits 8-bit grayscale at the same pixel rate, carrying tuser/tlast alongside the data. An optional line-length checker flags malformed lines before they reach the disparity engine.

## Interface
- WIDTH, 3840: active pixels per line.
- MAX_SAMPLES_PER_CLOCK, 4: pixels per beat; WIDTH must be a multiple of it.
- DATA_WIDTH, 8: bits per colour component and per gray sample.
- aclk  in  1  clock; all logic is on the rising edge.
- aresetn  in  1  synchronous, active-low reset.
- s_axis_tdata  in  3*DATA_WIDTH*MAX_SAMPLES_PER_CLOCK  RGB pixels.
- s_axis_tvalid / s_axis_tuser / s_axis_tlast  in  1 each  input beat valid / start of frame / end of line.
- s_axis_tready  out  1  input accept.
- m_axis_tdata  out  DATA_WIDTH*MAX_SAMPLES_PER_CLOCK  gray pixels.
- m_axis_tvalid / m_axis_tuser / m_axis_tlast  out  1 each.
- m_axis_tready  in  1  downstream accept.
- err_early_eol  out  1  sticky: tlast arrived before WIDTH pixels.
- err_late_eol  out  1  sticky: WIDTH pixels passed without tlast.
- err_sof_midline  out  1  sticky: tuser arrived on a beat that was not first in its line.

## Operation
- Pixel i occupies s_axis_tdata[24i+23:24i] with R=[23:16], B=[15:8], G=[7:0]. Gray pixel i goes to m_axis_tdata[8i+7:8i].
- Luma: Y = (77·R + 150·G + 29·B + 128) >> 8. The coefficients sum to 256.
- Accumulate in 16 bits unsigned; the maximum value is 65408, so no saturation is needed and Y ≤ 255.
- Pipeline has 3 stages:
  - S1: register the input beat.
  - S2: register the three products per pixel.
  - S3: register the sum, shift, and pack.
- tuser and tlast travel with their beat through every stage, unchanged.
- Stall control uses per-stage enables:
  - en3 = !v3 | m_axis_tready
  - en2 = !v2 | en3
  - en1 = !v1 | en2
  - s_axis_tready = en1
- Bubbles collapse and no beat is ever dropped or duplicated.
- Line checker, when compiled in, runs on accepted input beats (s_axis_tvalid & s_axis_tready):
  - beat counter counts 0 .. WIDTH/MAX_SAMPLES_PER_CLOCK−1.
  - tlast with counter < last: set err_early_eol and reset the counter to 0.
  - counter == last without tlast: set err_late_eol and wrap the counter to 0.
  - tuser with counter ≠ 0: set err_sof_midline and force the counter to 1.
  - tuser and tlast on the same beat: both rules apply; the tlast reset wins.
- The checker reports errors only; data still passes through unmodified.

## Timing
- Latency is 3 cycles from an input handshake to m_axis_tvalid for that beat when m_axis_tready is held high.
- Throughput is 1 beat/cycle.
- While the AXIS rules hold, m_axis_tdata, tuser and tlast stay stable while m_axis_tvalid=1 and m_axis_tready=0.
- s_axis_tready depends combinationally on m_axis_tready. There is no combinational path from s_axis_tvalid to any output.
- Reset state (aresetn=0 at an edge):
  - all stage valids, m_axis_tvalid, m_axis_tuser, m_axis_tlast = 0
  - m_axis_tdata = 0
  - error flags = 0
  - beat counter = 0
- Reset mid-operation discards all in-flight beats. s_axis_tready = 1 on the first cycle after reset deassertion.
- Error flags are set one cycle after the offending handshake. They clear only on reset.

## Configuration
- RGB2GRAY_LINE_CHECK_EN defined: the beat counter and the three sticky error flags are implemented as described.
- RGB2GRAY_LINE_CHECK_EN undefined: no counter logic is built. err_early_eol, err_late_eol and err_sof_midline are tied to 0. The datapath and timing are identical.

## Test plan
- Single pixels (R,G,B) = (255,255,255), (255,0,0), (0,255,0), (0,0,255), (100,100,100) in lanes 0..3 with m_axis_tready=1 -> gray 255, 77, 149, 29, 100 in the matching lanes exactly 3 cycles later.
- Continuous 4-beat burst with tuser on the first beat and tlast on the last -> 4 output beats on consecutive cycles, tuser/tlast on the same beats, no gaps.
- Random m_axis_tready (50%) over a 960-beat line of random data -> output matches the reference model in order, no loss or duplication, data held stable during stalls.
- Line of 959 beats ending in tlast, then a line of 961 beats (tlast on beat 961) with WIDTH=3840 -> err_early_eol=1 after the first line; err_late_eol=1 on beat 960 of the second line.
- tuser asserted on beat 5 of a line -> err_sof_midline=1 one cycle later. With the macro undefined, all three flags stay 0 for every case above.
- aresetn pulsed low for 1 cycle with 3 beats in flight -> m_axis_tvalid=0 and flags=0 the next cycle, no stale beats ever emitted, and a fresh beat sent after reset appears 3 cycles later.
